// File: rtl/difftest_vecreg_snapshot_sched_if.sv
// Snapshot scheduler bus: requester capture side plus the single beat output channel.
interface difftest_vecreg_snapshot_sched_if #(
   parameter int NUM_REQ   = 2,
   parameter int REGS      = 64,
   parameter int BEAT_REGS = 8
);
   localparam int BEATS = REGS / BEAT_REGS;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ-1:0]         req_ready;
   logic [NUM_REQ*REGS*64-1:0] req_value;
   logic [NUM_REQ*8-1:0]       req_coreid;
   logic                       out_valid;
   logic                       out_ready;
   logic [BEAT_REGS*64-1:0]    out_data;
   logic [BW-1:0]              out_beat;
   logic                       out_last;
   logic [7:0]                 out_coreid;
   logic                       busy;

   // Scheduler side
   modport slave (
      input  req_valid, req_value, req_coreid, out_ready,
      output req_ready, out_valid, out_data, out_beat, out_last, out_coreid, busy
   );

   // Producers + sink side
   modport master (
      output req_valid, req_value, req_coreid, out_ready,
      input  req_ready, out_valid, out_data, out_beat, out_last, out_coreid, busy
   );
endinterface

// File: rtl/difftest_vecreg_snapshot_sched.sv
// Round-robin capture of vector-register snapshots from NUM_REQ requesters,
// replayed to one difftest sink as REGS/BEAT_REGS valid/ready beats.
module difftest_vecreg_snapshot_sched #(
   parameter int NUM_REQ   = 2,
   parameter int REGS      = 64,
   parameter int BEAT_REGS = 8
) (
   input logic clock,
   input logic reset,
   difftest_vecreg_snapshot_sched_if.slave bus
);
   localparam int BEATS = REGS / BEAT_REGS;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state;
   logic [PW-1:0]       ptr;
   logic [BW-1:0]       beat;
   logic [REGS*64-1:0]  snap;
   logic [7:0]          coreid;
   logic                out_valid_q;

   logic [NUM_REQ-1:0]  grant;
   logic [PW-1:0]       win;
   logic                found;
   int                  idx;

   // Round-robin search starting just after the last winner; grant only in IDLE
   always_comb begin
      grant = '0;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         if (!found && bus.req_valid[idx]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
      if (state == IDLE && !reset && found)
         grant[win] = 1'b1;
   end

   assign bus.req_ready = grant;

   // Capture/replay FSM; the buffer is only written on a grant so it stays frozen during SEND
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= PW'(NUM_REQ - 1);
         beat        <= '0;
         snap        <= '0;
         coreid      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  snap        <= bus.req_value[int'(win)*REGS*64 +: REGS*64];
                  coreid      <= bus.req_coreid[int'(win)*8 +: 8];
                  ptr         <= win;
                  beat        <= '0;
                  state       <= SEND;
                  out_valid_q <= 1'b1;
               end
            end
            SEND: begin
               if (bus.out_ready) begin
                  if (beat == BW'(BEATS - 1)) begin
                     state       <= IDLE;
                     out_valid_q <= 1'b0;
                  end else begin
                     beat <= beat + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.busy       = out_valid_q;
   assign bus.out_beat   = beat;
   assign bus.out_last   = out_valid_q && (beat == BW'(BEATS - 1));
   assign bus.out_coreid = coreid;
   assign bus.out_data   = snap[int'(beat)*BEAT_REGS*64 +: BEAT_REGS*64];
endmodule

// File: doc/difftest_vecreg_snapshot_sched.md
# difftest_vecreg_snapshot_sched

Captures architectural vector-register snapshots (REGS × 64-bit values plus an 8-bit core ID) from several requesters and shares one narrow difftest output channel between them. Requesters are arbitrated round-robin. The winning snapshot is latched into an internal buffer, and the block replays it as REGS/BEAT_REGS valid/ready beats. The block sits between per-core snapshot producers and the single ArchVecRegState difftest sink, so a multi-core system needs only one sink instance.

## Interface
- NUM_REQ, 2, number of requesters (≥1)
- REGS, 64, 64-bit registers per snapshot
- BEAT_REGS, 8, registers per output beat; must divide REGS; BEATS = REGS/BEAT_REGS
- BW, max(1, clog2(BEATS)), beat-index width (derived)

- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  requester r has a snapshot pending; held until acked
- req_ready  out  NUM_REQ  one-hot capture grant; transfer when req_valid[r] & req_ready[r]
- req_value  in  NUM_REQ*REGS*64  reg i of requester r at [(r*REGS+i)*64 +: 64]
- req_coreid  in  NUM_REQ*8  core ID of requester r at [r*8 +: 8]
- out_valid  out  1  beat present
- out_ready  in  1  sink accepts beat
- out_data  out  BEAT_REGS*64  beat k: reg k*BEAT_REGS+j at [j*64 +: 64]
- out_beat  out  BW  index k of current beat
- out_last  out  1  out_beat == BEATS-1
- out_coreid  out  8  core ID of captured snapshot
- busy  out  1  high in SEND

## Operation
- FSM states: IDLE, SEND.
- IDLE:
  - req_ready is combinational: a one-hot grant to the first r with req_valid[r], searching from ptr+1 upward modulo NUM_REQ.
  - All zero when no request.
  - On a grant, the full snapshot and coreid of the winner are latched, ptr ← winner, beat ← 0, state → SEND.
- SEND:
  - req_ready = 0. out_valid = 1. out_data is the buffer slice for beat.
  - On out_valid & out_ready with beat < BEATS-1: beat ← beat+1.
  - On out_valid & out_ready with beat = BEATS-1: state → IDLE.
- Buffer contents and outputs are stable while out_valid & !out_ready. Requester inputs are ignored after capture.
- Fairness:
  - After a grant to r, r has lowest priority in the next arbitration.
  - A requester held continuously valid is granted within NUM_REQ captures.
- BEATS = 1: every accepted beat is last; out_beat is a constant 0.
- NUM_REQ = 1: the pointer is a degenerate constant 0, and the requester always wins.

## Timing
- Reset values:
  - state = IDLE
  - ptr = NUM_REQ-1, so requester 0 wins first
  - beat = 0
  - out_valid = 0, out_last = 0, busy = 0, req_ready = 0 while reset is high
  - out_data and out_coreid = 0 (buffer cleared)
- Reset mid-SEND aborts the transfer; the partial snapshot is discarded.
- Capture cycle t (IDLE, grant): first beat is valid at t+1.
- With out_ready held high, beats occupy t+1 … t+BEATS. IDLE is at t+BEATS+1, the earliest next capture, with its first beat at t+BEATS+2.
- Captures are never back-to-back with a last-beat acceptance. Minimum period is BEATS+1 cycles per snapshot.
- out_ready low for n cycles on any beat stretches the transfer by exactly n cycles.
- A requester asserting req_valid in the same cycle another is granted waits for the next IDLE.

## Test plan
- Single request, out_ready=1, NUM_REQ=2, REGS=64, BEAT_REGS=8:
  - stimulus: req_valid=2'b01, reg i = 64'h1000+i, coreid=8'h03
  - response: req_ready=2'b01 at cycle t; beats 0..7 at t+1..t+8; beat 2 word 0 = 64'h1010; out_last only at t+8; out_coreid=8'h03; busy low at t+9.
- Backpressure:
  - stimulus: out_ready low for 3 cycles at beat 4
  - response: out_data and out_beat=4 held; transfer ends 3 cycles later; no beat skipped or duplicated.
- Simultaneous requests:
  - stimulus: req_valid=2'b11 held continuously after reset
  - response: grants alternate 0, 1, 0, 1; each capture at 9-cycle spacing; out_coreid tracks the winner.
- Reset mid-transfer:
  - stimulus: reset at beat 5
  - response: next cycle out_valid=0, busy=0; after release the next request begins at beat 0; requester 0 has priority.
- Input change after capture:
  - stimulus: req_value modified during SEND
  - response: out_data still reflects the captured values.
- Idle:
  - stimulus: no req_valid for 20 cycles
  - response: out_valid=0, req_ready=0, ptr unchanged.
